gen_regfile_scan: RTL and testbench
===================================

// Module: gen_regfile_scan
//
// PURPOSE
// Parametrised register bank: NUM_REGS entries of DATA_W bits, one write port,
// one registered read port with write-through bypass, and a snapshot-scan engine
// that streams every entry out under a valid/ready handshake. Supersedes fixed
// 8-entry generate-loop banks with external 8:1 read mux. Sits between the
// datapath and debug/readback logic.
//
// PARAMETERS
// NUM_REGS  8                      number of entries, >=2, need not be power of 2
// DATA_W    8                      entry width in bits, >=1
// ADDR_W    $clog2(NUM_REGS)       address width, derived, not overridden
//
// PORTS
// clk         in   1       clock, all state on rising edge
// ar          in   1       synchronous active-high reset
// w_en        in   1       write enable
// w_addr      in   ADDR_W  write address
// wd          in   DATA_W  write data
// r_sel       in   ADDR_W  read address
// rd          out  DATA_W  registered read data
// rd_vld      out  1       rd holds a valid result
// scan_start  in   1       request snapshot scan (honoured only in IDLE)
// scan_ready  in   1       sink accepts current beat
// scan_valid  out  1       beat on scan_data/scan_idx is valid
// scan_data   out  DATA_W  snapshot entry value
// scan_idx    out  ADDR_W  index of current beat
// scan_busy   out  1       scan engine not IDLE
// scan_done   out  1       one-cycle pulse after final beat accepted
//
// BEHAVIOUR
// - Reset (ar=1 at edge): all entries, shadow copy, rd, rd_vld, scan_* outputs
//   -> 0; FSM -> IDLE. Applies mid-scan: scan aborted, no scan_done pulse.
// - Write: w_en=1 and w_addr<NUM_REGS -> mem[w_addr]<=wd at edge.
//   w_addr>=NUM_REGS: write dropped.
// - Read: 1-cycle latency. rd <= (w_en && w_addr==r_sel) ? wd : mem[r_sel]
//   (write-through bypass). r_sel>=NUM_REGS -> rd<=0. rd_vld<=1 every cycle
//   after reset deasserts.
// - Scan FSM, states IDLE, SCAN, DONE:
//   IDLE: scan_start=1 -> copy all of mem into shadow (pre-write values when
//     w_en same cycle), scan_idx<=0, go SCAN.
//   SCAN: scan_valid=1, scan_data=shadow[scan_idx]. Beat transfers when
//     scan_valid && scan_ready. Stalled: data/idx held stable. Transfer with
//     scan_idx<NUM_REGS-1 -> scan_idx+1. Transfer at NUM_REGS-1 -> DONE.
//   DONE: scan_valid=0, scan_done=1 for exactly one cycle, -> IDLE.
//   scan_busy=1 in SCAN and DONE. scan_start ignored outside IDLE.
// - Writes during scan update mem only; streamed values come from shadow.
// - Minimum scan: start edge + NUM_REGS beats + 1 DONE cycle.
//
// TESTING
// 1. ar=1 for 2 cycles -> all outputs 0; after release, read every address
//    -> rd=0, rd_vld=1.
// 2. Write mem[i]=8'h10+i for i=0..7; r_sel=4 -> rd=8'h14 one cycle later;
//    bypass: w_en=1, w_addr=3, wd=8'hA5, r_sel=3 same cycle -> rd=8'hA5 next
//    cycle.
// 3. Contents from 2, scan_ready=1 held: pulse scan_start -> 8 consecutive beats
//    idx 0..7, data 8'h10,8'h11,8'h12,8'hA5,8'h14..8'h17; scan_done next cycle;
//    scan_busy high 9 cycles.
// 4. Backpressure: scan_ready alternates 0/1; write addr 2 = 8'hFF during scan
//    -> beats unchanged and stable while stalled, beat 2 = 8'h12; subsequent
//    read of addr 2 -> 8'hFF.
// 5. ar=1 during beat 3 -> next cycle scan_valid=0, scan_busy=0, no scan_done;
//    new scan -> 8 beats all 0.
// 6. NUM_REGS=5, DATA_W=16: write addr 6 dropped, read addr 6 -> 0; scan emits
//    exactly 5 beats, idx 0..4.

Source files
------------

// File: rtl/gen_regfile_scan.sv
// Parametrised register bank with a registered, write-through read port and a
// snapshot-scan engine that streams every entry out under valid/ready.
module gen_regfile_scan #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned DATA_W   = 8,
    localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              ar,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] r_sel,
    output logic [DATA_W-1:0] rd,
    output logic              rd_vld,
    input  logic              scan_start,
    input  logic              scan_ready,
    output logic              scan_valid,
    output logic [DATA_W-1:0] scan_data,
    output logic [ADDR_W-1:0] scan_idx,
    output logic              scan_busy,
    output logic              scan_done
);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    localparam logic [ADDR_W:0]   NumRegsW = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(NUM_REGS - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]   rd_q, rd_d;
    logic                rd_vld_q, rd_vld_d;
    logic [DATA_W-1:0]   mem_q    [NUM_REGS];
    logic [DATA_W-1:0]   mem_d    [NUM_REGS];
    logic [DATA_W-1:0]   shadow_q [NUM_REGS];
    logic [DATA_W-1:0]   shadow_d [NUM_REGS];

    logic w_ok, r_ok;

    // Non-power-of-two banks leave some addresses unmapped.
    assign w_ok = {1'b0, w_addr} < NumRegsW;
    assign r_ok = {1'b0, r_sel} < NumRegsW;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mem_d    = mem_q;
        shadow_d = shadow_q;
        rd_d     = '0;
        rd_vld_d = 1'b1;

        if (r_ok) begin
            rd_d = (w_en && (w_addr == r_sel)) ? wd : mem_q[r_sel];
        end
        if (w_en && w_ok) begin
            mem_d[w_addr] = wd;
        end

        unique case (state_q)
            StIdle: begin
                // Snapshot takes pre-write contents, so a same-cycle write is not seen.
                if (scan_start) begin
                    shadow_d = mem_q;
                    idx_d    = '0;
                    state_d  = StScan;
                end
            end
            StScan: begin
                if (scan_ready) begin
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ar) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            rd_q     <= '0;
            rd_vld_q <= 1'b0;
            mem_q    <= '{default: '0};
            shadow_q <= '{default: '0};
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rd_q     <= rd_d;
            rd_vld_q <= rd_vld_d;
            mem_q    <= mem_d;
            shadow_q <= shadow_d;
        end
    end

    assign rd         = rd_q;
    assign rd_vld     = rd_vld_q;
    assign scan_valid = (state_q == StScan);
    assign scan_data  = shadow_q[idx_q];
    assign scan_idx   = idx_q;
    assign scan_busy  = (state_q != StIdle);
    assign scan_done  = (state_q == StDone);

endmodule

// File: tb/tb_gen_regfile_scan.sv
// Bench for gen_regfile_scan: an 8x8 and a 5x16 instance share stimulus and are
// checked every cycle against a snapshot/position reference model.
module tb_gen_regfile_scan;

    logic        clk;
    logic        ar;
    logic        w_en;
    logic [2:0]  w_addr;
    logic [15:0] wd;
    logic [2:0]  r_sel;
    logic        scan_start;
    logic        scan_ready;

    logic [7:0]  rd_a, sd_a;
    logic [2:0]  si_a;
    logic        vld_a, sv_a, sb_a, sdn_a;
    logic [15:0] rd_b, sd_b;
    logic [2:0]  si_b;
    logic        vld_b, sv_b, sb_b, sdn_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model, one slot per instance (0: 8x8, 1: 5x16).
    int          nregs [2] = '{8, 5};
    logic [15:0] mem_m  [2][8];
    logic [15:0] snap_m [2][8];
    logic [15:0] rd_m   [2];
    bit          vld_m  [2];
    bit          act_m  [2];
    bit          done_m [2];
    int          pos_m  [2];

    gen_regfile_scan #(.NUM_REGS(8), .DATA_W(8)) u_dut_a (
        .clk        (clk),
        .ar         (ar),
        .w_en       (w_en),
        .w_addr     (w_addr),
        .wd         (wd[7:0]),
        .r_sel      (r_sel),
        .rd         (rd_a),
        .rd_vld     (vld_a),
        .scan_start (scan_start),
        .scan_ready (scan_ready),
        .scan_valid (sv_a),
        .scan_data  (sd_a),
        .scan_idx   (si_a),
        .scan_busy  (sb_a),
        .scan_done  (sdn_a)
    );

    gen_regfile_scan #(.NUM_REGS(5), .DATA_W(16)) u_dut_b (
        .clk        (clk),
        .ar         (ar),
        .w_en       (w_en),
        .w_addr     (w_addr),
        .wd         (wd),
        .r_sel      (r_sel),
        .rd         (rd_b),
        .rd_vld     (vld_b),
        .scan_start (scan_start),
        .scan_ready (scan_ready),
        .scan_valid (sv_b),
        .scan_data  (sd_b),
        .scan_idx   (si_b),
        .scan_busy  (sb_b),
        .scan_done  (sdn_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [15:0] g_rd, g_sd;
        logic [2:0]  g_si;
        logic        g_vld, g_sv, g_sb, g_sdn;
        string       p;
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                p = "A"; g_rd = {8'h0, rd_a}; g_sd = {8'h0, sd_a}; g_si = si_a;
                g_vld = vld_a; g_sv = sv_a; g_sb = sb_a; g_sdn = sdn_a;
            end else begin
                p = "B"; g_rd = rd_b; g_sd = sd_b; g_si = si_b;
                g_vld = vld_b; g_sv = sv_b; g_sb = sb_b; g_sdn = sdn_b;
            end
            check_eq({p, " rd"}, 32'(g_rd), 32'(rd_m[d]));
            check_eq({p, " rd_vld"}, 32'(g_vld), 32'(vld_m[d]));
            check_eq({p, " scan_valid"}, 32'(g_sv), 32'(act_m[d]));
            check_eq({p, " scan_busy"}, 32'(g_sb), 32'(act_m[d] || done_m[d]));
            check_eq({p, " scan_done"}, 32'(g_sdn), 32'(done_m[d]));
            if (act_m[d]) begin
                check_eq({p, " scan_data"}, 32'(g_sd), 32'(snap_m[d][pos_m[d]]));
                check_eq({p, " scan_idx"}, 32'(g_si), 32'(pos_m[d]));
            end
        end
    endtask

    // Advances the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        int          n;
        logic [15:0] val;
        bit          nd;
        for (int d = 0; d < 2; d++) begin
            n   = nregs[d];
            val = (d == 0) ? {8'h0, wd[7:0]} : wd;
            if (ar) begin
                for (int i = 0; i < 8; i++) begin
                    mem_m[d][i]  = '0;
                    snap_m[d][i] = '0;
                end
                rd_m[d] = '0; vld_m[d] = 0; act_m[d] = 0; done_m[d] = 0; pos_m[d] = 0;
            end else begin
                if (int'(r_sel) < n)
                    rd_m[d] = (w_en && w_addr == r_sel) ? val : mem_m[d][r_sel];
                else
                    rd_m[d] = '0;
                vld_m[d] = 1;
                nd = 0;
                if (act_m[d]) begin
                    if (scan_ready) begin
                        pos_m[d]++;
                        if (pos_m[d] == n) begin
                            act_m[d] = 0;
                            nd       = 1;
                            pos_m[d] = 0;
                        end
                    end
                end else if (!done_m[d] && scan_start) begin
                    for (int i = 0; i < 8; i++) snap_m[d][i] = mem_m[d][i];
                    act_m[d] = 1;
                    pos_m[d] = 0;
                end
                done_m[d] = nd;
                if (w_en && int'(w_addr) < n) mem_m[d][w_addr] = val;
            end
        end
    endtask

    // Called at the falling edge with inputs applied; returns at the next falling edge.
    task automatic cycle(input bit chk);
        if (chk) check_outputs();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    int busy_a, busy_b, beats_a, beats_b, done_a, done_b;
    logic [7:0] beat3_a;

    initial begin
        ar = 1'b1; w_en = 1'b0; w_addr = '0; wd = '0; r_sel = '0;
        scan_start = 1'b0; scan_ready = 1'b0;
        @(negedge clk);

        // Reset held two cycles, then every address reads back zero.
        cycle(0);
        cycle(1);
        ar = 1'b0;
        check_eq("rst scan_data", 32'(sd_a), 32'h0);
        check_eq("rst scan_idx", 32'(si_a), 32'h0);
        check_eq("rst rd_vld", 32'(vld_a), 32'h0);
        for (int i = 0; i < 8; i++) begin
            r_sel = 3'(i);
            cycle(1);
        end
        cycle(1);

        // Fill, registered read, write-through bypass.
        for (int i = 0; i < 8; i++) begin
            w_en = 1'b1; w_addr = 3'(i); wd = 16'h0010 + 16'(i);
            cycle(1);
        end
        w_en = 1'b0; r_sel = 3'd4;
        cycle(1);
        check_eq("t2 rd4", 32'(rd_a), 32'h14);
        w_en = 1'b1; w_addr = 3'd3; wd = 16'h00A5; r_sel = 3'd3;
        cycle(1);
        w_en = 1'b0;
        check_eq("t2 bypass", 32'(rd_a), 32'hA5);

        // Full-speed scan.
        busy_a = 0; busy_b = 0; beats_a = 0; beats_b = 0; done_a = 0; done_b = 0;
        beat3_a = '0;
        scan_ready = 1'b1; scan_start = 1'b1;
        cycle(1);
        scan_start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            busy_a += int'(sb_a); busy_b += int'(sb_b);
            done_a += int'(sdn_a); done_b += int'(sdn_b);
            if (sv_a && si_a == 3'd3) beat3_a = sd_a;
            beats_a += int'(sv_a); beats_b += int'(sv_b);
            cycle(1);
        end
        check_eq("t3 busy cycles A", 32'(busy_a), 32'd9);
        check_eq("t3 beats A", 32'(beats_a), 32'd8);
        check_eq("t3 beat3 A", 32'(beat3_a), 32'hA5);
        check_eq("t3 done pulses A", 32'(done_a), 32'd1);
        check_eq("t6 beats B", 32'(beats_b), 32'd5);
        check_eq("t6 busy cycles B", 32'(busy_b), 32'd6);

        // Backpressure with a write to entry 2 mid-scan.
        scan_start = 1'b1; scan_ready = 1'b0;
        cycle(1);
        scan_start = 1'b0;
        for (int k = 0; k < 24; k++) begin
            scan_ready = k[0];
            w_en = (k == 3); w_addr = 3'd2; wd = 16'h00FF;
            cycle(1);
        end
        w_en = 1'b0; scan_ready = 1'b1;
        check_eq("t4 idle after scan", 32'(sb_a), 32'h0);
        r_sel = 3'd2;
        cycle(1);
        check_eq("t4 rd2 after write", 32'(rd_a), 32'hFF);

        // Reset while beat 3 is presented aborts without a done pulse.
        scan_start = 1'b1;
        cycle(1);
        scan_start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (sv_a && si_a == 3'd3) break;
            cycle(1);
        end
        check_eq("t5 reached beat3", 32'(si_a), 32'd3);
        ar = 1'b1;
        cycle(1);
        ar = 1'b0;
        check_eq("t5 valid after rst", 32'(sv_a), 32'h0);
        check_eq("t5 busy after rst", 32'(sb_a), 32'h0);
        cycle(1);
        check_eq("t5 no done", 32'(sdn_a), 32'h0);
        scan_start = 1'b1;
        cycle(1);
        scan_start = 1'b0;
        for (int k = 0; k < 12; k++) cycle(1);

        // Unmapped address on the 5-entry bank.
        w_en = 1'b1; w_addr = 3'd6; wd = 16'hBEEF; r_sel = 3'd6;
        cycle(1);
        w_en = 1'b0;
        check_eq("t6 rd6 B", 32'(rd_b), 32'h0);
        check_eq("t6 rd6 A bypass", 32'(rd_a), 32'hEF);
        cycle(1);
        check_eq("t6 rd6 B dropped", 32'(rd_b), 32'h0);

        // Randomised traffic.
        for (int k = 0; k < 500; k++) begin
            ar         = ($urandom_range(0, 99) == 0);
            w_en       = $urandom_range(0, 1) == 1;
            w_addr     = 3'($urandom_range(0, 7));
            wd         = 16'($urandom);
            r_sel      = 3'($urandom_range(0, 7));
            scan_start = ($urandom_range(0, 7) == 0);
            scan_ready = ($urandom_range(0, 3) != 0);
            cycle(1);
        end
        ar = 1'b0; w_en = 1'b0; scan_start = 1'b0;
        cycle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
